// File: rtl/rgb_led_scheduler.sv
// rgb_led_scheduler
//   Shares one RGB LED between NUM_REQ requesters using round-robin
//   arbitration. The winning requester's colour and duration are latched.
//   The LED is then driven for exactly that many prescaled ticks. A one-tick
//   blank gap follows, and then the scheduler arbitrates again.
//
// Ports
//   clk               system clock, all logic on posedge
//   reset             synchronous, active-high reset
//   req   [NUM_REQ]   per-requester request level
//   color [2*NUM_REQ] requester i colour at [2i+1:2i]
//                     00 blank, 01 red, 11 green, 10 blue
//   dur   [DUR_W*NUM_REQ] requester i duration in ticks (0 behaves as 1)
//   abort             ends the current show early (SHOW state only)
//   gnt   [NUM_REQ]   one-hot grant pulse, one cycle
//   done  [NUM_REQ]   one-hot completion pulse, first GAP cycle
//   busy              registered (state != IDLE)
//   red/green/blue    registered LED drives, at most one high
module rgb_led_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DUR_W      = 8,
    parameter int PRESCALE_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     color,
    input  logic [DUR_W*NUM_REQ-1:0] dur,
    input  logic                     abort,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     red,
    output logic                     green,
    output logic                     blue
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    logic [1:0]            state_reg;
    logic [PTR_W-1:0]      ptr_reg;
    logic [PTR_W-1:0]      owner_reg;
    logic [DUR_W-1:0]      dur_m1_reg;
    logic [PRESCALE_W-1:0] prescale_reg;
    logic [DUR_W-1:0]      tick_cnt_reg;
    logic [NUM_REQ-1:0]    gnt_reg;
    logic [NUM_REQ-1:0]    done_reg;
    logic                  busy_reg;
    logic                  red_reg;
    logic                  green_reg;
    logic                  blue_reg;

    // Per-requester views of the packed colour and duration buses
    logic [1:0]       color_arr [NUM_REQ];
    logic [DUR_W-1:0] dur_arr   [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign color_arr[gi] = color[2*gi +: 2];
            assign dur_arr[gi]   = dur[DUR_W*gi +: DUR_W];
        end
    endgenerate

    // Round-robin search starting at ptr+1. The scan runs from the farthest
    // candidate back toward ptr+1, so the nearest set bit is the last one
    // written and therefore the one that wins.
    logic [PTR_W-1:0] winner;
    logic             found;

    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idx_w;
        winner = ptr_reg;
        found  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = PTR_W'(idx);
            if (req[idx_w]) begin
                winner = idx_w;
                found  = 1'b1;
            end
        end
    end

    logic tick;
    logic last_tick;

    assign tick      = &prescale_reg;
    assign last_tick = tick && (tick_cnt_reg == dur_m1_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= PTR_W'(NUM_REQ - 1);
            owner_reg    <= '0;
            dur_m1_reg   <= '0;
            prescale_reg <= '0;
            tick_cnt_reg <= '0;
            gnt_reg      <= '0;
            done_reg     <= '0;
            busy_reg     <= 1'b0;
            red_reg      <= 1'b0;
            green_reg    <= 1'b0;
            blue_reg     <= 1'b0;
        end else begin
            gnt_reg  <= '0;
            done_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (found) begin
                        gnt_reg      <= ONE_HOT0 << winner;
                        ptr_reg      <= winner;
                        owner_reg    <= winner;
                        // Store dur_eff-1 so the terminal compare is direct.
                        // A zero duration behaves as a one-tick show.
                        dur_m1_reg   <= (dur_arr[winner] == '0) ? '0
                                        : dur_arr[winner] - DUR_W'(1);
                        prescale_reg <= '0;
                        tick_cnt_reg <= '0;
                        state_reg    <= ST_SHOW;
                        busy_reg     <= 1'b1;
                        red_reg      <= (color_arr[winner] == 2'b01);
                        green_reg    <= (color_arr[winner] == 2'b11);
                        blue_reg     <= (color_arr[winner] == 2'b10);
                    end else begin
                        busy_reg  <= 1'b0;
                        red_reg   <= 1'b0;
                        green_reg <= 1'b0;
                        blue_reg  <= 1'b0;
                    end
                end
                ST_SHOW: begin
                    // Abort and the final tick share one exit path, so a
                    // coincident pair still produces a single done pulse.
                    if (abort || last_tick) begin
                        state_reg    <= ST_GAP;
                        prescale_reg <= '0;
                        done_reg     <= ONE_HOT0 << owner_reg;
                        red_reg      <= 1'b0;
                        green_reg    <= 1'b0;
                        blue_reg     <= 1'b0;
                    end else begin
                        prescale_reg <= prescale_reg + PRESCALE_W'(1);
                        if (tick) begin
                            tick_cnt_reg <= tick_cnt_reg + DUR_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    prescale_reg <= prescale_reg + PRESCALE_W'(1);
                    if (tick) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    prescale_reg <= '0;
                    tick_cnt_reg <= '0;
                    busy_reg     <= 1'b0;
                    red_reg      <= 1'b0;
                    green_reg    <= 1'b0;
                    blue_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = gnt_reg;
    assign done  = done_reg;
    assign busy  = busy_reg;
    assign red   = red_reg;
    assign green = green_reg;
    assign blue  = blue_reg;

endmodule

// File: tb/tb_rgb_led_scheduler.sv
// tb_rgb_led_scheduler
//   Scoreboard bench for rgb_led_scheduler (NUM_REQ=4, DUR_W=8, PRESCALE_W=2).
//   The stimulus pushes the expected output events, tagged with a cycle
//   number, into a queue. The monitor pops one entry per observed event.
//   Event kinds: 0 gnt pulse, 1 done pulse, 2 busy change, 3 LED change.
module tb_rgb_led_scheduler;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int PW = 2;

    localparam logic [2:0] LED_R = 3'b100;
    localparam logic [2:0] LED_G = 3'b010;
    localparam logic [2:0] LED_B = 3'b001;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req   = '0;
    logic [2*NR-1:0]   color = '0;
    logic [DW*NR-1:0]  dur   = '0;
    logic              abort = 1'b0;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     done;
    logic              busy;
    logic              red;
    logic              green;
    logic              blue;

    rgb_led_scheduler #(
        .NUM_REQ    (NR),
        .DUR_W      (DW),
        .PRESCALE_W (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .color (color),
        .dur   (dur),
        .abort (abort),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .red   (red),
        .green (green),
        .blue  (blue)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb [$];
    logic        mon_en    = 1'b0;
    logic        prev_busy = 1'b0;
    logic [2:0]  prev_led  = 3'b000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end else begin
            $display("[TB] ok %s %0h (cyc %0d)", tag, got, cyc);
        end
    endtask

    function automatic logic [63:0] mk(input int kind, input int val, input int c);
        return {20'd0, kind[3:0], val[7:0], c[31:0]};
    endfunction

    task automatic push_ev(input int kind, input int val, input int c);
        sb.push_back(mk(kind, val, c));
    endtask

    task automatic push_start(input int id, input logic [2:0] rgb, input int s);
        push_ev(0, 1 << id, s);
        push_ev(2, 1, s);
        if (rgb != 3'b000) push_ev(3, int'(rgb), s);
    endtask

    // Full show: start at s, done/LED-off at s+len, busy drops after 4 gap cycles
    task automatic push_show(input int id, input logic [2:0] rgb, input int s, input int len);
        push_start(id, rgb, s);
        push_ev(1, 1 << id, s + len);
        if (rgb != 3'b000) push_ev(3, 0, s + len);
        push_ev(2, 0, s + len + 4);
    endtask

    task automatic observe(input logic [63:0] ev);
        if (sb.size() == 0) check("sb_unexpected", ev, 64'd0);
        else                check("sb_event", ev, sb.pop_front());
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (gnt != '0)  observe(mk(0, int'(gnt), cyc));
            if (done != '0) observe(mk(1, int'(done), cyc));
            if (busy != prev_busy) observe(mk(2, int'(busy), cyc));
            if ({red, green, blue} != prev_led) begin
                observe(mk(3, int'({red, green, blue}), cyc));
                check("led_onehot", 64'($countones({red, green, blue}) <= 1), 64'd1);
            end
            prev_busy = busy;
            prev_led  = {red, green, blue};
        end
    end

    task automatic set_req_cfg(input int id, input logic [1:0] col, input int d);
        color[2*id +: 2] = col;
        dur[DW*id +: DW] = d[DW-1:0];
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("timeout_pending", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired (cyc %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;

        // 1: reset held three cycles with all requests high
        req = 4'b1111;
        set_req_cfg(0, 2'b11, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", 64'({gnt, done, busy, red, green, blue}), 64'd0);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        s = cyc + 1;
        push_show(0, LED_G, s, 4);
        @(negedge clk);
        req = '0;
        wait_idle(100);

        // 2: requester 1, red, 3 ticks
        @(negedge clk);
        set_req_cfg(1, 2'b01, 3);
        req[1] = 1'b1;
        s = cyc + 1;
        push_show(1, LED_R, s, 12);
        @(negedge clk);
        req = '0;
        wait_idle(100);

        // 4: requester 3, zero duration behaves as one tick, blue
        @(negedge clk);
        set_req_cfg(3, 2'b10, 0);
        req[3] = 1'b1;
        s = cyc + 1;
        push_show(3, LED_B, s, 4);
        @(negedge clk);
        req = '0;
        wait_idle(100);

        // 3: requesters 0 and 2 held continuously, alternating grants
        @(negedge clk);
        set_req_cfg(0, 2'b11, 1);
        set_req_cfg(2, 2'b10, 1);
        req = 4'b0101;
        s = cyc + 1;
        push_show(0, LED_G, s,      4);
        push_show(2, LED_B, s + 9,  4);
        push_show(0, LED_G, s + 18, 4);
        push_show(2, LED_B, s + 27, 4);
        while (cyc < s + 27) @(negedge clk);
        req = '0;
        wait_idle(100);

        // 5: requester 1, 10 ticks, aborted in the sixth show cycle
        @(negedge clk);
        set_req_cfg(1, 2'b01, 10);
        req[1] = 1'b1;
        s = cyc + 1;
        push_show(1, LED_R, s, 6);
        @(negedge clk);
        req = '0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle(100);

        // 6: reset in the fifth cycle of a 3-tick red show, then re-arbitrate
        @(negedge clk);
        set_req_cfg(0, 2'b01, 3);
        req[0] = 1'b1;
        s = cyc + 1;
        push_start(0, LED_R, s);
        @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        push_ev(2, 0, s + 5);
        push_ev(3, 0, s + 5);
        @(negedge clk);
        reset = 1'b0;
        set_req_cfg(0, 2'b11, 1);
        set_req_cfg(1, 2'b01, 1);
        req = 4'b0011;
        push_show(0, LED_G, s + 6, 4);
        @(negedge clk);
        req = '0;
        wait_idle(100);

        repeat (10) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
